// File: rtl/collenda_pushbutton_debounce_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : collenda_pushbutton_debounce_ctrl_if
// Brief    : Avalon-MM slave bus bundle for the pushbutton controller.
// Revision : 1.0
// ============================================================================
interface collenda_pushbutton_debounce_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface
`default_nettype wire

// File: rtl/collenda_pushbutton_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : collenda_pushbutton_debounce_ctrl
// Brief    : Synchronise, debounce and capture presses of active-low buttons;
//            maskable level interrupt over an Avalon-MM slave.
// Revision : 1.0
// ============================================================================
module collenda_pushbutton_debounce_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    collenda_pushbutton_debounce_ctrl_if.slave   bus,
    input  logic [WIDTH-1:0]                     in_port
);

    localparam logic [CNT_W-1:0] c_term = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_intmask;
    logic [WIDTH-1:0] r_edgecapture;
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_fall;
    logic             w_wr;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_edgecapture_nxt;
    logic [WIDTH-1:0] w_intmask_nxt;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    // Counter restarts whenever the input agrees with the accepted level,
    // so only an uninterrupted run of DEBOUNCE_CYCLES samples is accepted.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_W-1:0] r_cnt;

            assign w_accept[gi] = (r_sync2[gi] != r_stable[gi]) && (r_cnt == c_term);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if ((r_sync2[gi] == r_stable[gi]) || w_accept[gi]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    assign w_fall            = r_stable & w_accept;
    assign w_wr              = bus.chipselect & ~bus.write_n;
    assign w_clr             = (w_wr && (bus.address == 2'd3)) ? bus.writedata[WIDTH-1:0] : '0;
    assign w_edgecapture_nxt = (r_edgecapture & ~w_clr) | w_fall;
    assign w_intmask_nxt     = (w_wr && (bus.address == 2'd1)) ? bus.writedata[WIDTH-1:0] : r_intmask;
    assign w_unused_wdata    = ^bus.writedata;

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            2'd0:    w_rdata[WIDTH-1:0] = r_stable;
            2'd1:    w_rdata[WIDTH-1:0] = r_intmask;
            2'd3:    w_rdata[WIDTH-1:0] = r_edgecapture;
            default: w_rdata = '0;
        endcase
    end

    // irq is registered from the next-state values so it moves on the same
    // edge as the capture/clear/mask update that causes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable      <= '1;
            r_intmask     <= '0;
            r_edgecapture <= '0;
            r_readdata    <= '0;
            r_irq         <= 1'b0;
        end else begin
            r_stable      <= r_stable ^ w_accept;
            r_intmask     <= w_intmask_nxt;
            r_edgecapture <= w_edgecapture_nxt;
            r_readdata    <= w_rdata;
            r_irq         <= |(w_edgecapture_nxt & w_intmask_nxt);
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = r_irq;

endmodule
`default_nettype wire
